// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline registers.
// Holds the IF/ID handshake state encoding and the default-width entry record.
package mips_pipe_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int PC_INCR     = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } ifid_state_t;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [PC_W_DEF-1:0]    pc4;
        logic [INSTR_W_DEF-1:0] instr;
    } ifid_entry_t;

    // Entry width in bits for a given PC/instruction width pair.
    function automatic int entry_bits(input int pc_w, input int instr_w);
        return 2 * pc_w + instr_w;
    endfunction

endpackage : mips_pipe_pkg

// File: rtl/ifid_entry_reg.sv
// Enable-gated, synchronously reset storage for one IF/ID entry.
// Used for both the main (visible) entry and the skid entry.
module ifid_entry_reg
    import mips_pipe_pkg::*;
#(
    parameter int W = entry_bits(PC_W_DEF, INSTR_W_DEF)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = en ? d : data_q;
    end

    // NOTE: data is reset too, not just the valid state, so no X can ever reach decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            // NOTE: non-blocking assignment for every flop so all state updates see pre-edge values.
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : ifid_entry_reg

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer; in_ready depends only on
// registered state, so decode's ready never reaches fetch combinationally.
module ifid_skid_reg
    import mips_pipe_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc4,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int ENTRY_W = entry_bits(PC_W, INSTR_W);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc4;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    ifid_state_t state_d;
    ifid_state_t state_q;

    entry_t in_entry;
    entry_t main_d;
    entry_t main_q;
    entry_t skid_q;

    logic accept;
    logic consume;
    logic main_en;
    logic skid_en;
    logic main_from_skid;

    assign in_ready  = (state_q != FULL2);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // PC+4 is computed once at capture and wraps modulo 2^PC_W.
    always_comb begin
        in_entry       = '0;
        in_entry.pc    = in_pc;
        in_entry.pc4   = in_pc + PC_W'(PC_INCR);
        in_entry.instr = in_instr;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_en = 1'b1;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    state_d = FULL2;
                    skid_en = 1'b1;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL2: begin
                if (consume) begin
                    state_d        = ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // A redirect kills everything held; a same-cycle consume has already been taken by decode.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_comb begin
        main_d = main_from_skid ? skid_q : in_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    ifid_entry_reg #(
        .W (ENTRY_W)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    ifid_entry_reg #(
        .W (ENTRY_W)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign out_pc    = main_q.pc;
    assign out_pc4   = main_q.pc4;
    assign out_instr = main_q.instr;

endmodule : ifid_skid_reg
